// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg : shared constants and duty clamp helper for the PWM channel bank
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

  localparam int MODE_EDGE   = 0;
  localparam int MODE_CENTER = 1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Saturates a signed value into the unsigned range [0, 2^width-1].
  function automatic int clamp_duty(input int value, input int width);
    int max_v;
    max_v = (1 << width) - 1;
    if (value < 0) begin
      return 0;
    end else if (value > max_v) begin
      return max_v;
    end else begin
      return value;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel : one PWM output with shadow/active duty and registered output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int OFFSET = 0,
  parameter int CENTER = MODE_EDGE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] counter_i,
  input  logic             boundary_i,
  input  logic             pending_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             invert_i,
  output logic             pwm_o
);

  localparam logic signed [WIDTH+1:0] C_OFFSET = (WIDTH+2)'(OFFSET);
  localparam logic [WIDTH-1:0]        C_MAX    = {WIDTH{1'b1}};

  logic [WIDTH-1:0]        shadow_q;
  logic [WIDTH-1:0]        active_q;
  logic                    pwm_q;
  logic signed [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0]        w_clamped;
  logic                    w_raw;

  assign w_sum     = $signed({2'b00, duty_i}) + C_OFFSET;
  assign w_clamped = WIDTH'(clamp_duty(int'(w_sum), WIDTH));

  // Full-scale duty in center mode never reaches the counter peak, so force it high.
  assign w_raw = (counter_i < active_q) ||
                 ((CENTER == MODE_CENTER) && (active_q == C_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= invert_i;
    end else begin
      if (boundary_i && pending_i) begin
        active_q <= shadow_q;
      end
      if (load_i) begin
        shadow_q <= w_clamped;
      end
      pwm_q <= enable_i ? (w_raw ^ invert_i) : invert_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_channel_bank.sv
// ---------------------------------------------------------------------------
// pwm_channel_bank : shared prescaler/period counter driving CHANNELS PWM outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_channel_bank
  import pwm_pkg::*;
#(
  parameter int                  CHANNELS = 6,
  parameter int                  WIDTH    = 10,
  parameter int                  OFFSET   = 0,
  parameter int                  PRESCALE = 1,
  parameter int                  CENTER   = MODE_EDGE,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      pending
);

  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    C_PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] C_MAX     = {WIDTH{1'b1}};

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             pending_q;
  logic             period_start_q;
  logic             w_tick;
  logic             w_boundary;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    w_tick  = (presc_q == C_PS_LAST);
    if (w_tick) begin
      presc_d = '0;
      if (CENTER == MODE_CENTER) begin
        cnt_d = (dir_q == DIR_DOWN) ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
        if (cnt_d == C_MAX) begin
          dir_d = DIR_DOWN;
        end else if (cnt_d == '0) begin
          dir_d = DIR_UP;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // The counter sitting at 0 after reset/enable is not a boundary; only an arrival is.
    w_boundary = enable && w_tick && (cnt_d == '0) && (cnt_q != '0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      period_start_q <= 1'b0;
    end else if (!enable) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      period_start_q <= w_boundary;
    end
  end

  // A load coinciding with a boundary keeps pending set for the freshly captured set.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (load) begin
      pending_q <= 1'b1;
    end else if (w_boundary) begin
      pending_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    pwm_channel #(
      .WIDTH (WIDTH),
      .OFFSET(OFFSET),
      .CENTER(CENTER)
    ) u_chan (
      .clk_i     (CLOCK_50),
      .rst_i     (reset),
      .enable_i  (enable),
      .counter_i (cnt_q),
      .boundary_i(w_boundary),
      .pending_i (pending_q),
      .load_i    (load),
      .duty_i    (duty_in[gi*WIDTH +: WIDTH]),
      .invert_i  (INVERT[gi]),
      .pwm_o     (pwm_out[gi])
    );
  end

  assign period_start = period_start_q;
  assign pending      = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_channel_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_channel_bank : directed checks over five parameter configurations
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_channel_bank;

  logic       clk = 1'b0;
  logic       rst  [5];
  logic       en   [5];
  logic       ld   [5];
  logic [7:0] duty [5];
  logic [1:0] pwm  [5];
  logic       ps   [5];
  logic       pend [5];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // 0: edge, inv 10 | 1: offset -3 | 2: offset +3 | 3: center | 4: prescale 3, inv 01
  pwm_channel_bank #(.CHANNELS(2), .WIDTH(4), .OFFSET(0), .PRESCALE(1), .CENTER(0), .INVERT(2'b10)) u_a (
    .CLOCK_50(clk), .reset(rst[0]), .enable(en[0]), .duty_in(duty[0]), .load(ld[0]),
    .pwm_out(pwm[0]), .period_start(ps[0]), .pending(pend[0]));
  pwm_channel_bank #(.CHANNELS(2), .WIDTH(4), .OFFSET(-3), .PRESCALE(1), .CENTER(0), .INVERT(2'b00)) u_b (
    .CLOCK_50(clk), .reset(rst[1]), .enable(en[1]), .duty_in(duty[1]), .load(ld[1]),
    .pwm_out(pwm[1]), .period_start(ps[1]), .pending(pend[1]));
  pwm_channel_bank #(.CHANNELS(2), .WIDTH(4), .OFFSET(3), .PRESCALE(1), .CENTER(0), .INVERT(2'b00)) u_c (
    .CLOCK_50(clk), .reset(rst[2]), .enable(en[2]), .duty_in(duty[2]), .load(ld[2]),
    .pwm_out(pwm[2]), .period_start(ps[2]), .pending(pend[2]));
  pwm_channel_bank #(.CHANNELS(2), .WIDTH(4), .OFFSET(0), .PRESCALE(1), .CENTER(1), .INVERT(2'b00)) u_d (
    .CLOCK_50(clk), .reset(rst[3]), .enable(en[3]), .duty_in(duty[3]), .load(ld[3]),
    .pwm_out(pwm[3]), .period_start(ps[3]), .pending(pend[3]));
  pwm_channel_bank #(.CHANNELS(2), .WIDTH(4), .OFFSET(0), .PRESCALE(3), .CENTER(0), .INVERT(2'b01)) u_e (
    .CLOCK_50(clk), .reset(rst[4]), .enable(en[4]), .duty_in(duty[4]), .load(ld[4]),
    .pwm_out(pwm[4]), .period_start(ps[4]), .pending(pend[4]));

  typedef struct {
    int         d;
    logic [3:0] d0;
    logic [3:0] d1;
    int         e0;
    int         e1;
  } vec_t;

  vec_t vecs [7];

  function automatic int inv_of(input int d);
    case (d)
      0:       return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    ld[d]  = 1'b0;
    en[d]  = 1'b1;
    step();
    rst[d] = 1'b0;
  endtask

  task automatic do_load(input int d, input logic [3:0] d0, input logic [3:0] d1);
    duty[d] = {d1, d0};
    ld[d]   = 1'b1;
    step();
    ld[d]   = 1'b0;
  endtask

  // Steps until period_start is seen; n = -1 if the bound expires.
  task automatic wait_ps(input int d, input int limit, output int n, output int hi0);
    n   = -1;
    hi0 = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      hi0 += pwm[d][0] ? 1 : 0;
      if (ps[d]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic measure(input int d, input int len, output int h0, output int h1,
                         output int psn, output int last_ps, output int rises0);
    logic s [64];
    h0 = 0; h1 = 0; psn = 0; rises0 = 0;
    for (int i = 0; i < len; i++) begin
      step();
      s[i] = pwm[d][0];
      h0  += pwm[d][0] ? 1 : 0;
      h1  += pwm[d][1] ? 1 : 0;
      psn += ps[d] ? 1 : 0;
    end
    last_ps = ps[d] ? 1 : 0;
    for (int i = 0; i < len; i++) begin
      if (s[i] && !s[(i + len - 1) % len]) rises0++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hi, h0, h1, psn, lps, rises, bad;

    vecs[0] = '{0,  4'd5, 4'd0,  5, 16};
    vecs[1] = '{0, 4'd15, 4'd7, 15,  9};
    vecs[2] = '{1,  4'd2, 4'd14, 0, 11};
    vecs[3] = '{1,  4'd0, 4'd3,  0,  0};
    vecs[4] = '{1, 4'd15, 4'd9, 12,  6};
    vecs[5] = '{2, 4'd14, 4'd5, 15,  8};
    vecs[6] = '{2, 4'd12, 4'd0, 15,  3};

    for (int d = 0; d < 5; d++) begin
      rst[d] = 1'b1; en[d] = 1'b1; ld[d] = 1'b0; duty[d] = '0;
    end
    step();
    for (int d = 0; d < 5; d++) begin
      check($sformatf("reset_pwm[%0d]", d), int'(pwm[d]), inv_of(d));
      check($sformatf("reset_ps[%0d]", d), int'(ps[d]), 0);
      check($sformatf("reset_pending[%0d]", d), int'(pend[d]), 0);
      rst[d] = 1'b0;
    end

    // Table: load, first boundary 16 clocks after reset, high time over one period.
    for (int k = 0; k < 7; k++) begin
      do_reset(vecs[k].d);
      do_load(vecs[k].d, vecs[k].d0, vecs[k].d1);
      check($sformatf("vec%0d_pending_set", k), int'(pend[vecs[k].d]), 1);
      wait_ps(vecs[k].d, 100, n, hi);
      check($sformatf("vec%0d_first_boundary", k), n, 15);
      check($sformatf("vec%0d_pending_clr", k), int'(pend[vecs[k].d]), 0);
      measure(vecs[k].d, 16, h0, h1, psn, lps, rises);
      check($sformatf("vec%0d_high_ch0", k), h0, vecs[k].e0);
      check($sformatf("vec%0d_high_ch1", k), h1, vecs[k].e1);
      check($sformatf("vec%0d_ps_count", k), psn, 1);
      check($sformatf("vec%0d_ps_at_end", k), lps, 1);
    end

    // Two loads before a boundary: last wins; active stays 0 until then.
    do_reset(0);
    do_load(0, 4'd3, 4'd0);
    do_load(0, 4'd9, 4'd0);
    check("twoload_pending", int'(pend[0]), 1);
    wait_ps(0, 100, n, hi);
    check("twoload_boundary", n, 14);
    check("twoload_low_before", hi, 0);
    measure(0, 16, h0, h1, psn, lps, rises);
    check("twoload_high", h0, 9);

    // Load on the exact boundary clock lands one period later.
    do_load(0, 4'd2, 4'd0);
    for (int i = 0; i < 14; i++) step();
    duty[0] = {4'd0, 4'd4};
    ld[0]   = 1'b1;
    step();
    ld[0]   = 1'b0;
    check("bndload_ps", int'(ps[0]), 1);
    check("bndload_pending_kept", int'(pend[0]), 1);
    measure(0, 16, h0, h1, psn, lps, rises);
    check("bndload_prior_applied", h0, 2);
    check("bndload_pending_clr", int'(pend[0]), 0);
    measure(0, 16, h0, h1, psn, lps, rises);
    check("bndload_new_applied", h0, 4);

    // Enable low: idle outputs, no period_start, loads still accepted.
    en[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pwm[0] != 2'b10 || ps[0]) bad++;
    end
    check("disabled_idle_cycles_bad", bad, 0);
    do_load(0, 4'd3, 4'd7);
    check("disabled_load_pending", int'(pend[0]), 1);
    en[0] = 1'b1;
    wait_ps(0, 100, n, hi);
    check("enable_restart_boundary", n, 16);
    check("enable_pending_clr", int'(pend[0]), 0);
    measure(0, 16, h0, h1, psn, lps, rises);
    check("enable_high_ch0", h0, 3);
    check("enable_high_ch1", h1, 9);

    // Center-aligned: 30-clock period, one 11-clock pulse.
    do_reset(3);
    do_load(3, 4'd6, 4'd0);
    wait_ps(3, 100, n, hi);
    check("center_first_boundary", n, 29);
    measure(3, 30, h0, h1, psn, lps, rises);
    check("center_high", h0, 11);
    check("center_single_pulse", rises, 1);
    check("center_ps_count", psn, 1);
    check("center_ps_at_end", lps, 1);

    // Prescale 3: 48-clock period; mid-period reset.
    do_reset(4);
    do_load(4, 4'd5, 4'd10);
    wait_ps(4, 200, n, hi);
    check("presc_first_boundary", n, 47);
    measure(4, 48, h0, h1, psn, lps, rises);
    check("presc_high_ch0_inv", h0, 33);
    check("presc_high_ch1", h1, 30);
    check("presc_ps_count", psn, 1);
    check("presc_ps_at_end", lps, 1);
    for (int i = 0; i < 20; i++) step();
    do_load(4, 4'd9, 4'd9);
    check("midreset_pending_before", int'(pend[4]), 1);
    rst[4] = 1'b1;
    step();
    rst[4] = 1'b0;
    check("midreset_pwm", int'(pwm[4]), 1);
    check("midreset_pending", int'(pend[4]), 0);
    check("midreset_ps", int'(ps[4]), 0);
    wait_ps(4, 200, n, hi);
    check("midreset_counter_restart", n, 48);
    measure(4, 48, h0, h1, psn, lps, rises);
    check("midreset_high_ch0_idle", h0, 48);
    check("midreset_high_ch1_idle", h1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Parametrised multi-channel PWM generator replacing the per-signal single-channel PWM instances (LED visualisation of IMU axes, motor drive). One shared period counter drives CHANNELS comparators. Each channel has a double-buffered duty register, so new IMU or filter samples are applied only at a period boundary. Adds an offset/clamp stage, edge- or center-aligned mode, a prescaler, a per-channel output inversion mask, and a global enable.

## Interface
- CHANNELS, 6, number of PWM outputs (1..16)
- WIDTH, 10, duty/counter width in bits; full scale MAX = 2^WIDTH-1
- OFFSET, 0, signed integer added to every loaded duty before clamping
- PRESCALE, 1, counter advances once every PRESCALE clocks (1..65535)
- CENTER, 0, 0 = edge-aligned, 1 = center-aligned
- INVERT, 0, CHANNELS-bit mask; bit i set inverts pwm_out[i]
---
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  high = run; low = counter held at 0, outputs idle
- duty_in  in  CHANNELS*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH]
- load  in  1  single-cycle strobe; captures all of duty_in
- pwm_out  out  CHANNELS  PWM outputs, registered
- period_start  out  1  one-cycle pulse on the tick the counter returns to 0
- pending  out  1  high while a captured duty set awaits the next boundary

## Operation
- Reset values:
  - counter = 0, direction = up, prescaler = 0
  - shadow and active duties = 0
  - pending = 0, period_start = 0
  - pwm_out = INVERT (idle level)
- Tick: prescaler counts 0..PRESCALE-1 and asserts tick when it reaches PRESCALE-1. With PRESCALE=1, tick is asserted every cycle.
- Edge mode:
  - counter runs 0..MAX and wraps to 0.
  - Period = 2^WIDTH ticks.
- Center mode:
  - counter counts up 0..MAX, then down to 1, then back to 0.
  - Direction reverses at MAX and at 0.
  - Period = 2*MAX ticks.
- Boundary: the tick on which the counter becomes 0. In center mode this is the down-count arrival at 0.
- Load:
  - On load, each channel computes d = duty_in[i] + OFFSET, clamped to [0, MAX] using WIDTH+2-bit signed arithmetic.
  - The clamped value is written to shadow[i] and pending is set.
  - A repeated load before the boundary overwrites shadow (last load wins).
- Transfer: at a boundary with pending = 1, active <= shadow for all channels simultaneously, and pending clears.
- Compare: raw[i] = (counter < active[i]); pwm_out[i] = raw[i] XOR INVERT[i].
  - Duty 0 gives constant idle.
  - Duty MAX gives MAX/2^WIDTH high time in edge mode and 100% in center mode.
- Enable low:
  - counter, direction and prescaler reset to their reset values; duty registers retained.
  - pwm_out = INVERT; period_start = 0.
  - Loads are still accepted.

## Timing
- pwm_out[t+1] reflects the counter and active duty at t (1 clock latency).
- period_start is asserted in the same cycle the counter register holds 0 after a boundary tick. It is registered together with the counter update.
- load at cycle t: shadow and pending valid at t+1.
- Simultaneous load and boundary:
  - the prior shadow transfers to active;
  - the new value lands in shadow;
  - pending remains 1 and the new value applies at the next boundary.
- The first boundary after reset or enable rise occurs one full period later. The counter starting at 0 is not itself a boundary.
- reset mid-period: all state returns to reset values on the next clock edge, and pending loads are discarded.
- Rising enable: the counter starts advancing from 0 on the next tick.

## Structure
- Shared package pwm_pkg:
  - mode constants MODE_EDGE = 0, MODE_CENTER = 1;
  - clamp function clamp_duty(signed value, WIDTH).
- Sub-module pwm_channel, instantiated CHANNELS times from a generate loop:
  - holds shadow, active and the output register;
  - inputs: counter, boundary, load, duty slice, invert bit, enable.
- Top level holds the prescaler, counter, direction, pending and period_start.

## Test plan
- Edge, WIDTH=4, PRESCALE=1, load duty 5 on ch0:
  - after the first boundary, ch0 is high for exactly 5 of every 16 cycles;
  - period_start pulses every 16 cycles.
- OFFSET=-3, load 2 on ch0 and 14 on ch1 (WIDTH=4): active duties are 0 and 11. With OFFSET=+3 and 14 loaded, active is 15.
- Two loads (3, then 9) before a boundary: active goes from 0 to 9 at the boundary. A load on the exact boundary cycle is applied one period later, and pending stays 1.
- CENTER=1, WIDTH=4, duty 6: the period is 30 cycles and ch0 is high 11 cycles per period, in a single high pulse centred on counter = 0.
- INVERT=2'b10, enable low: pwm_out = 2'b10 and period_start never pulses. Raising enable restarts the counter at 0.
- PRESCALE=3: period is 48 clocks (WIDTH=4, edge). A reset asserted mid-period gives pwm_out = INVERT, pending = 0 and counter = 0 on the next edge.
